// File: rtl/regfile.sv
// regfile -- general-purpose register file behind the writeback mux.
//
// Two asynchronous read ports (A1/RD1, A2/RD2) feed the ALU operand muxes;
// one synchronous write port (WE3/A3/WD3) is driven by the writeback mux.
// Register 0 always reads as zero and cannot be written.
//
// Ports:
//   clk      rising-edge system clock
//   reset    synchronous, active-high; clears every register and WRITTEN
//   WE3      write enable
//   A1, A2   read addresses (r bits)
//   A3       write address (r bits)
//   WD3      write data (n bits)
//   RD1, RD2 read data (n bits), combinational
//   WRITTEN  per-register flag, bit i set once register i is written
//
// Parameters:
//   n       data width
//   r       address width, depth = 2**r
//   BYPASS  1: a read of the register being written returns WD3 this cycle
module regfile #(
  parameter int n      = 32,
  parameter int r      = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE3,
  input  logic [r-1:0]      A1,
  input  logic [r-1:0]      A2,
  input  logic [r-1:0]      A3,
  input  logic [n-1:0]      WD3,
  output logic [n-1:0]      RD1,
  output logic [n-1:0]      RD2,
  output logic [2**r-1:0]   WRITTEN
);

  localparam int DEPTH = 2**r;

  logic [n-1:0]     regs [DEPTH];
  logic [DEPTH-1:0] written_q;
  logic             wr_en;

  // Writes to register 0 are dropped so it stays zero and never flags.
  assign wr_en = WE3 && (A3 != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      written_q <= '0;
    end else if (wr_en) begin
      regs[A3]      <= WD3;
      written_q[A3] <= 1'b1;
    end
  end

  always_comb begin
    RD1 = '0;
    if (A1 != '0) begin
      if (BYPASS && wr_en && (A1 == A3)) RD1 = WD3;
      else                               RD1 = regs[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (A2 != '0) begin
      if (BYPASS && wr_en && (A2 == A3)) RD2 = WD3;
      else                               RD2 = regs[A2];
    end
  end

  assign WRITTEN = written_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE3;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic [31:0] wr_b, wr_n;

  always #5 clk = ~clk;

  regfile #(.n(32), .r(5), .BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .RD1(rd1_b), .RD2(rd2_b), .WRITTEN(wr_b)
  );

  regfile #(.n(32), .r(5), .BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .WE3(WE3), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .RD1(rd1_n), .RD2(rd2_n), .WRITTEN(wr_n)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] e1b, e2b, e1n, e2n;
    logic [31:0] ew;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [32];
  logic [31:0] model_wr;
  int          checks = 0;
  int          errors = 0;

  // Expected read for one port under the register-file rules.
  function automatic logic [31:0] mread(input logic [4:0] a, input bit byp,
                                        input logic we, input logic [4:0] a3,
                                        input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && we && a3 != 5'd0 && a == a3) return wd;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one cycle, queue the expected pre-edge outputs,
  // then advance the model across the edge.
  task automatic drive(input logic rst, input logic we, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd);
    exp_t e;
    reset = rst; WE3 = we; A1 = a1; A2 = a2; A3 = a3; WD3 = wd;
    e.chk_rd = !(rst && we);
    e.e1b = mread(a1, 1'b1, we, a3, wd);
    e.e2b = mread(a2, 1'b1, we, a3, wd);
    e.e1n = mread(a1, 1'b0, we, a3, wd);
    e.e2n = mread(a2, 1'b0, we, a3, wd);
    e.ew  = model_wr;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_wr = 32'd0;
    end else if (we && a3 != 5'd0) begin
      model[a3]    = wd;
      model_wr[a3] = 1'b1;
    end
    #1;
  endtask

  // Monitor: compare queued expectations against both instances mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_rd) begin
          check("rd1_bypass", rd1_b, e.e1b);
          check("rd2_bypass", rd2_b, e.e2b);
          check("rd1_nobypass", rd1_n, e.e1n);
          check("rd2_nobypass", rd2_n, e.e2n);
        end
        check("written_bypass", wr_b, e.ew);
        check("written_nobypass", wr_n, e.ew);
      end
    end
  end

  initial begin
    logic [4:0] a1, a2, a3;
    int         wait_cycles;
    reset = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_wr = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset clears a written register
    drive(0, 1, 5, 0, 5, 32'h8000_0000);
    drive(0, 0, 5, 5, 0, 32'h0);
    drive(1, 0, 5, 5, 0, 32'h0);
    drive(0, 0, 5, 5, 0, 32'h0);
    // Basic write/read
    drive(0, 1, 0, 0, 3, 32'h0000_0001);
    drive(0, 0, 3, 3, 0, 32'h0);
    // Register zero protected
    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0, 32'h0);
    // Bypass: reg 7 old 0x11111111, same-cycle write 0x22222222
    drive(0, 1, 0, 0, 7, 32'h1111_1111);
    drive(0, 1, 7, 7, 7, 32'h2222_2222);
    drive(0, 0, 7, 7, 0, 32'h0);
    // Reset beats write, then reset held with writes blocked
    drive(1, 1, 9, 9, 9, 32'hDEAD_BEEF);
    drive(1, 1, 9, 9, 9, 32'h1234_5678);
    drive(0, 0, 9, 9, 0, 32'h0);
    // First write after reset release accepted
    drive(0, 1, 9, 9, 9, 32'hCAFE_F00D);
    drive(0, 0, 9, 30, 0, 32'h0);
    // Back-to-back writes to reg 31, A2=31 throughout
    drive(0, 1, 30, 31, 31, 32'h0000_000A);
    drive(0, 1, 30, 31, 31, 32'h0000_000B);
    drive(0, 0, 30, 31, 0, 32'h0);

    // Randomized traffic with address collisions encouraged
    for (int k = 0; k < 400; k++) begin
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            a1, a2, a3, $urandom);
    end
    reset = 1'b0; WE3 = 1'b0;

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Register file fed directly by the writeback 2:1 multiplexer. That mux selects ALU result vs. memory read data onto WD3.
- Two asynchronous read ports feed the ALU operand muxes; one synchronous write port.
- Register 0 is hardwired to zero.
- Optional same-cycle write-to-read bypass, plus a per-register written flag for the debug/trace bench.

Parameters:
- n, 32, data width in bits
- r, 5, address width in bits; depth = 2**r registers
- BYPASS, 1, 1 = a read of the register being written this cycle returns WD3; 0 = returns the old contents

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- WE3  input  1  write enable
- A1  input  r  read address, port 1
- A2  input  r  read address, port 2
- A3  input  r  write address
- WD3  input  n  write data (from writeback mux2 output Y)
- RD1  output  n  read data, port 1
- RD2  output  n  read data, port 2
- WRITTEN  output  2**r  bit i = 1 once register i has been written since reset

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - On a rising edge with reset=1, all registers go to 0 and WRITTEN goes to all zeros.
  - Reset has priority over a simultaneous WE3=1; that write is discarded.
- Reset values after a reset edge:
  - RD1 = 0 and RD2 = 0 for any address, provided WE3=0.
  - WRITTEN = 0.
- Write:
  - On a rising edge with reset=0, WE3=1 and A3!=0: reg[A3] <= WD3 and WRITTEN[A3] <= 1.
  - Latency 1 cycle; new data is visible on RD1/RD2 combinationally after the edge.
- Writes to A3=0 are ignored. reg[0] stays 0 and WRITTEN[0] stays 0 forever.
- Read: RD1 and RD2 are combinational from A1 and A2, with no clock latency.
  - A1==0 returns 0; A2==0 returns 0.
- Bypass with BYPASS=1:
  - If WE3=1, A3!=0 and A1==A3, then RD1 = WD3 in the same cycle, before the edge. Same rule for RD2 with A2.
  - Both ports may bypass at once.
- BYPASS=0: RD1/RD2 return the stored value until the edge.
- Both read ports may address the same register; both return identical data.
- Reset held for multiple cycles: the file stays cleared and writes stay blocked.
- Reset deasserted mid-sequence: the first write is accepted on the first edge with reset=0.
- WE3, A3 and WD3 are don't-care when reset=1.
- No X propagation:
  - Every register has a defined value after the first reset.
  - Before the first reset, contents are unspecified; the bench must apply reset first.
- Width rules:
  - WD3 is stored unmodified, all n bits.
  - Addresses wider than r do not exist; all 2**r addresses are legal.

Test Plan:
1. Reset clears the file: write 0x80000000 to reg 5, then assert reset for 1 cycle -> RD1(A1=5)=0x00000000, WRITTEN=0.
2. Basic write/read: WE3=1, A3=3, WD3=0x00000001, one edge; then A1=3, A2=3 -> RD1=RD2=0x00000001, WRITTEN[3]=1, all other WRITTEN bits 0.
3. Register zero is protected: WE3=1, A3=0, WD3=0xFFFFFFFF, one edge -> RD1(A1=0)=0, WRITTEN[0]=0.
4. Bypass with BYPASS=1: reg 7 holds 0x11111111. Before the edge drive WE3=1, A3=7, WD3=0x22222222, A1=7 -> RD1=0x22222222 before the edge. With BYPASS=0, RD1=0x11111111 before the edge and 0x22222222 after it.
5. Reset beats write: reset=1, WE3=1, A3=9, WD3=0xDEADBEEF on the same edge -> RD1(A1=9)=0, WRITTEN[9]=0.
6. Back-to-back writes: write 0xA to reg 31, then 0xB to reg 31 on consecutive edges, with A2=31 throughout -> RD2 shows 0xA after edge 1 and 0xB after edge 2; reg 30 is unchanged at 0.
